noc_output_arbiter: RTL and testbench
=====================================

// Module: noc_output_arbiter
// PURPOSE
//  Output-port merge stage of the 5-port mesh router, directly downstream of the per-input switch demuxes.
//  Collects single-flit packets from the 4 switches that can target this output (the other in-directions).
//  Round-robin arbitrates among them and buffers winners in a small output FIFO.
//  Drives one output link (N/E/S/W/PE) toward the neighbour router or local PE.
// PARAMETERS
//  WIDTH    33   flit width: [32] ifm/filt, [31:28] dest addr, [27:24] src addr, [23:0] data
//  NUM_IN   4    number of requesting switch outputs merged here
//  DEPTH    2    output FIFO entries (power of 2, >=2)
//  PORT_ID  3'd0 output direction: 0 N, 1 E, 2 S, 3 W, 4 PE; tags debug only, no functional effect
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             synchronous reset, active-low
//  in_valid   in   NUM_IN        per-input flit valid
//  in_data    in   NUM_IN*WIDTH  input i at [i*WIDTH +: WIDTH]
//  in_ready   out  NUM_IN        one-hot (or zero) accept strobe
//  out_valid  out  1             FIFO head valid
//  out_data   out  WIDTH         FIFO head flit
//  out_ready  in   1             downstream accepts
//  pkt_count  out  16            flits delivered on out, saturating
// BEHAVIOUR
//  - Transfer on any link = valid && ready at rising clk. Senders hold valid/data stable until transfer.
//  - Senders must not derive valid from ready.
//  - Reset (rst_n=0 at edge): FIFO count=0, rd/wr ptr=0, rr_ptr=0, pkt_count=0.
//    out_valid=0, out_data=0, in_ready=0 while rst_n=0.
//    Reset mid-operation discards buffered flits; no partial transfer completes that cycle.
//  - pop = out_valid && out_ready. can_push = (count<DEPTH) || pop; push permitted when FULL if pop same cycle.
//  - Arbitration (combinational): when can_push, grant the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., mod NUM_IN.
//    in_ready[g]=1 for the granted input only; all others 0. If no request or !can_push, in_ready=0.
//  - On grant: FIFO[wr_ptr] <= in_data[g]. rr_ptr <= (g+1) mod NUM_IN. rr_ptr holds when no grant.
//  - Fairness: with all inputs continuously valid, grants rotate 0,1,2,3,0,...; any input waits <= NUM_IN-1 grants.
//  - Latency: flit accepted at edge k appears on out_data/out_valid after edge k (1 cycle) when FIFO was empty. No bypass path.
//  - out_valid = (count!=0). out_data = FIFO[rd_ptr]; holds stable while out_valid && !out_ready.
//  - Count: push&&!pop +1; pop&&!push -1; both -> unchanged. Pointers wrap mod DEPTH.
//  - Occupancy states EMPTY(count=0) / PARTIAL / FULL(count=DEPTH):
//    EMPTY: no pop possible.
//    FULL && !out_ready: all in_ready=0.
//    FULL && out_ready: one grant accepted.
//  - pkt_count += 1 on each pop; saturates at 16'hFFFF.
//  - Flit contents pass unmodified: no address check, no field rewrite.
// STRUCTURE
//  - noc_pkg: FLIT_W=33; field positions TYPE_BIT=32, DST_MSB/LSB=31/28, SRC_MSB/LSB=27/24, DATA_W=24.
//    Also holds typedef enum logic[2:0] {DIR_N,DIR_E,DIR_S,DIR_W,DIR_PE}.
//  - Sub-module rr_arbiter #(N): inputs req[N], en, clk, rst_n; outputs one-hot gnt[N].
//    Owns rr_ptr and its update. Top holds FIFO, handshake glue and counter.
// TESTING
//  1. Reset: rst_n=0 two cycles with in_valid=4'hF -> in_ready=0, out_valid=0, out_data=0, pkt_count=0.
//  2. Single: in_valid=4'b0100, data=33'h1_2E5C_B6B8, out_ready=1 -> in_ready=4'b0100 cycle 0.
//     out_valid=1, out_data=33'h1_2E5C_B6B8 next cycle; pkt_count=1.
//  3. Round-robin: all 4 valid with distinct data, out_ready=1, 8 cycles -> grant order 0,1,2,3,0,1,2,3; pkt_count=8 after drain.
//  4. Back-pressure: out_ready=0, in_valid=4'hF -> exactly 2 grants (inputs 0,1), then in_ready=0.
//     Raise out_ready -> outputs in order 0,1 and input 2 granted in the same cycle as the first pop.
//  5. Full + simultaneous: FIFO full, out_ready=1, in_valid=4'b1000 -> pop and push in same cycle; count stays 2.
//  6. Reset mid-flight: FIFO holding 2 flits, rst_n=0 one cycle -> out_valid=0, count=0, rr_ptr=0.
//     Next single request from input 1 is granted.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared flit layout, direction tags and occupancy encoding for the mesh router.
package noc_pkg;

  localparam int unsigned FLIT_W   = 33;
  localparam int unsigned TYPE_BIT = 32;
  localparam int unsigned DST_MSB  = 31;
  localparam int unsigned DST_LSB  = 28;
  localparam int unsigned SRC_MSB  = 27;
  localparam int unsigned SRC_LSB  = 24;
  localparam int unsigned DATA_W   = 24;

  typedef enum logic [2:0] {
    DIR_N,
    DIR_E,
    DIR_S,
    DIR_W,
    DIR_PE
  } dir_e;

  typedef struct packed {
    logic              ifm;
    logic [3:0]        dst;
    logic [3:0]        src;
    logic [DATA_W-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from rr_ptr; pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(rr_ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = PTR_W'((32'(gnt_idx) + 32'd1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Router output merge: round-robin across switch outputs into a small FIFO driving one link.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH   = FLIT_W,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DEPTH   = 2,
  parameter logic [2:0]  PORT_ID = 3'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [15:0]             pkt_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // PORT_ID only tags the instance for debug; this block has no hardware.
  if (PORT_ID > 3'(DIR_PE)) begin : g_port_id_out_of_range
  end

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  occ_e              occ;
  logic              pop;
  logic              push;
  logic              can_push;
  logic [NUM_IN-1:0] gnt;
  logic [WIDTH-1:0]  push_data;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == CNT_W'(DEPTH)) begin
      occ = OCC_FULL;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of stale storage.
  assign out_valid = rst_n && (occ != OCC_EMPTY);
  assign out_data  = rst_n ? mem_q[rd_ptr_q] : '0;
  assign pop       = out_valid && out_ready;
  assign can_push  = rst_n && ((occ != OCC_FULL) || pop);

  rr_arbiter #(
    .N(NUM_IN)
  ) u_rr_arbiter (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (in_valid),
    .en   (can_push),
    .gnt  (gnt)
  );

  assign in_ready = gnt;
  assign push     = |gnt;

  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        push_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (pkt_count_q != 16'hFFFF) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter with a flit scoreboard on the output link.
module tb_noc_output_arbiter;

  localparam int unsigned W = 33;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [15:0]    pkt_count;

  logic [W-1:0]   sb_q [$];
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  noc_output_arbiter #(
    .WIDTH  (W),
    .NUM_IN (N),
    .DEPTH  (2),
    .PORT_ID(3'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .pkt_count(pkt_count)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  // One clock: check in_ready and any pop mid-cycle, record accepted flits, return at edge+1.
  task automatic step(input logic [N-1:0] exp_rdy, input string tag);
    @(negedge clk);
    chk({tag, " in_ready"}, W'(in_ready), W'(exp_rdy));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk({tag, " spurious pop"}, W'(out_valid), W'(1'b0));
      end else begin
        chk({tag, " out_data"}, out_data, sb_q.pop_front());
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (in_ready[i] && in_valid[i]) begin
        sb_q.push_back(in_data[i*W +: W]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] e;
    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with all inputs requesting
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", W'(in_ready), W'(0));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset out_data", out_data, W'(0));
    chk("reset pkt_count", W'(pkt_count), W'(0));

    // Single flit from input 2
    rst_n     = 1'b1;
    in_valid  = 4'b0100;
    set_in(2, 33'h1_2E5C_B6B8);
    out_ready = 1'b1;
    step(4'b0100, "single grant");
    in_valid = '0;
    chk("single out_valid", W'(out_valid), W'(1));
    chk("single out_data", out_data, 33'h1_2E5C_B6B8);
    step('0, "single drain");
    chk("single pkt_count", W'(pkt_count), W'(1));
    chk("single empty", W'(out_valid), W'(0));

    // Realign the round-robin pointer
    rst_n = 1'b0;
    step('0, "realign reset");
    rst_n = 1'b1;
    chk("realign pkt_count", W'(pkt_count), W'(0));

    // Round-robin with all inputs valid
    for (int i = 0; i < int'(N); i++) set_in(i, {1'b0, 4'(i), 4'hA, 24'(32'h111 * i)});
    in_valid  = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = 4'b0001 << (k % 4);
      step(e, $sformatf("rr k=%0d", k));
      set_in(k % 4, {1'b0, 4'(k % 4), 4'hA, 24'(32'h2000 + k)});
    end
    in_valid = '0;
    step('0, "rr drain");
    chk("rr pkt_count", W'(pkt_count), W'(8));
    chk("rr empty", W'(out_valid), W'(0));

    // Back-pressure fills the FIFO with inputs 0,1
    for (int i = 0; i < int'(N); i++) set_in(i, {1'b1, 4'(i), 4'h5, 24'(32'hB0000 + i)});
    out_ready = 1'b0;
    in_valid  = '1;
    step(4'b0001, "bp grant0");
    step(4'b0010, "bp grant1");
    step('0, "bp full");
    chk("bp hold data", out_data, {1'b1, 4'd0, 4'h5, 24'hB0000});
    step('0, "bp full again");
    chk("bp hold data 2", out_data, {1'b1, 4'd0, 4'h5, 24'hB0000});
    out_ready = 1'b1;
    step(4'b0100, "bp pop0 grant2");
    in_valid = '0;
    step('0, "bp pop1");
    step('0, "bp pop2");
    chk("bp empty", W'(out_valid), W'(0));
    chk("bp pkt_count", W'(pkt_count), W'(11));

    // Full FIFO with pop and push in the same cycle
    out_ready = 1'b0;
    in_valid  = 4'b1000;
    set_in(3, 33'h0_3F00_00F0);
    step(4'b1000, "full grant3 a");
    set_in(3, 33'h0_3F00_00F1);
    step(4'b1000, "full grant3 b");
    set_in(3, 33'h0_3F00_00F2);
    step('0, "full blocked");
    out_ready = 1'b1;
    step(4'b1000, "full pop+push");
    out_ready = 1'b0;
    set_in(3, 33'h0_3F00_00F3);
    step('0, "full count stays 2");
    in_valid  = '0;
    out_ready = 1'b1;
    step('0, "full drain a");
    step('0, "full drain b");
    chk("full empty", W'(out_valid), W'(0));
    chk("full pkt_count", W'(pkt_count), W'(14));

    // Reset with two flits buffered
    for (int i = 0; i < int'(N); i++) set_in(i, {1'b0, 4'(i), 4'hC, 24'(32'hC000 + i)});
    out_ready = 1'b0;
    in_valid  = '1;
    step(4'b0001, "mf grant0");
    step(4'b0010, "mf grant1");
    chk("mf out_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    #1;
    chk("mf reset out_valid", W'(out_valid), W'(0));
    chk("mf reset out_data", out_data, W'(0));
    step('0, "mf in reset");
    sb_q.delete();
    rst_n    = 1'b1;
    in_valid = 4'b0101;
    #1;
    chk("mf post-reset out_valid", W'(out_valid), W'(0));
    step(4'b0001, "mf rr_ptr cleared");
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    step(4'b0010, "mf single in1");
    in_valid = '0;
    step('0, "mf drain");
    chk("mf empty", W'(out_valid), W'(0));
    chk("mf pkt_count", W'(pkt_count), W'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
